// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG,
    S_WIMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/instr_decoder.sv
// Splits the instruction register into its fields and sign-extends the 8-bit immediate.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8
);

  always_comb begin
    opcode = ir[15:13];
    op     = ir[12:11];
    rn     = ir[10:8];
    rd     = ir[7:5];
    sh     = ir[4:3];
    rm     = ir[2:0];
    sximm8 = {{8{ir[7]}}, ir[7:0]};
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, multi-cycle control FSM and status-flag latch for the datapath.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  input  logic              Z_in,
  input  logic              N_in,
  input  logic              V_in,
  output logic              w,
  output logic [REG_W-1:0]  readnum,
  output logic [REG_W-1:0]  writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              asel,
  output logic [1:0]        vsel,
  output logic [1:0]        ALU_op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm8,
  output logic              Z,
  output logic              N,
  output logic              V
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic        is_cmp, is_mov_reg;

  instr_decoder u_dec (
    .ir    (ir_q),
    .opcode(opcode),
    .op    (op),
    .rn    (rn),
    .rd    (rd),
    .sh    (sh),
    .rm    (rm),
    .sximm8(sximm8)
  );

  assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
    end else begin
      state_q <= state_d;
      // IR is only writable while idle so an in-flight instruction cannot be corrupted.
      if (state_q == S_WAIT && load) ir_q <= in;
      if (state_q == S_EXEC && is_cmp) begin
        Z <= Z_in;
        N <= N_in;
        V <= V_in;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    asel     = 1'b0;
    vsel     = VSEL_C;
    ALU_op   = ALU_ADD;
    shift    = 2'b00;
    unique case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_d = S_WIMM;
        else if (is_mov_reg)                            state_d = S_GETB;
        else if (opcode == OPC_ALU && op == OP_MVN)     state_d = S_GETB;
        else if (opcode == OPC_ALU)                     state_d = S_GETA;
        else                                            state_d = S_WAIT;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GETB;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        // MOV Rd,Rm computes 0 + B with the A operand forced to zero.
        if (is_mov_reg) begin
          asel   = 1'b1;
          ALU_op = ALU_ADD;
        end else begin
          ALU_op = op;
        end
        if (is_cmp) begin
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WREG;
        end
      end
      S_WREG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WIMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
